fft_bitrev_loader: RTL

- Input reorder stage directly upstream of the FFT pipeline.
- Accepts complex samples in natural time order, one frame of N = 2^LOG2N samples at a time.
- Emits each frame in bit-reversed index order, which is what the radix-2 DIT pipeline consumes.
- Ping-pong double buffer: one bank fills while the other drains, so streaming runs at full rate.

---
 rtl/fft_bitrev_loader_pkg.sv | 29 ++
 rtl/fft_bitrev_loader_if.sv | 33 +++
 rtl/fft_pingpong_ram.sv | 28 ++
 rtl/fft_bitrev_loader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fft_bitrev_loader_pkg.sv
// Shared definitions for the FFT front end: default sizes, frame length and
// the bit-reversal index helper used by the loader (and by later FFT stages).
package fft_bitrev_loader_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int LOG2N_DEFAULT  = 3;
    localparam int BITREV_MAX_W   = 16;

    // Frame length N = 2^log2n.
    function automatic int frame_len(input int log2n);
        return 1 << log2n;
    endfunction

    // Reverse the low nbits bits of idx; bits above nbits come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] idx,
        input int                      nbits
    );
        logic [BITREV_MAX_W-1:0] result;
        result = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < nbits) begin
                result[i] = idx[nbits-1-i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_bitrev_loader_if.sv
// Sample streams around the bit-reverse loader: natural-order input stream
// from upstream and bit-reversed output stream towards the FFT pipeline.
interface fft_bitrev_loader_if
    import fft_bitrev_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic              out_last;
    logic              out_bank;

    // Source/sink side: drives input samples, accepts reordered samples.
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last, out_bank
    );

    // Loader side.
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last, out_bank
    );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one combinational read
// port. Address MSB selects the bank. No reset so it maps onto plain RAM.
module fft_pingpong_ram #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    // Write the accepted sample into its slot on the clock edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_bitrev_loader.sv
// Bit-reverse reorder stage in front of the radix-2 DIT FFT. Frames arrive in
// natural order into one bank while the other bank drains in bit-reversed
// order through a single output register.
module fft_bitrev_loader
    import fft_bitrev_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LOG2N  = LOG2N_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_bitrev_loader_if.slave bus
);

    localparam int             N        = frame_len(LOG2N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_ptr;
    logic [LOG2N-1:0] rd_ptr;
    logic [1:0]       full;
    logic [1:0]       full_next;

    logic             wr_fire;
    logic             wr_last;
    logic             rd_advance;
    logic             rd_fire;
    logic             rd_last;
    logic [LOG2N-1:0] rd_idx;

    logic [LOG2N:0]    wr_addr;
    logic [LOG2N:0]    rd_addr;
    logic [2*DATA_W-1:0] wr_data;
    logic [2*DATA_W-1:0] rd_data;

    // A bank being written is accepted only while it is not waiting to drain.
    assign bus.in_ready = ~full[wr_bank];
    assign wr_fire      = bus.in_valid & ~full[wr_bank];
    assign wr_last      = (wr_ptr == LAST_IDX);

    // The output register may take a new sample when empty or being consumed.
    assign rd_advance = ~bus.out_valid | bus.out_ready;
    assign rd_fire    = rd_advance & full[rd_bank];
    assign rd_last    = (rd_ptr == LAST_IDX);
    assign rd_idx     = LOG2N'(bitrev(BITREV_MAX_W'(rd_ptr), LOG2N));

    assign wr_addr = {wr_bank, wr_ptr};
    assign wr_data = {bus.in_re, bus.in_im};
    assign rd_addr = {rd_bank, rd_idx};

    fft_pingpong_ram #(
        .WORD_W (2 * DATA_W),
        .ADDR_W (LOG2N + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Full flags: completing a frame marks its bank full, loading its last
    // element releases the draining bank; the two banks never collide because
    // a bank is written only while empty and released only while full.
    always_comb begin
        full_next = full;
        if (wr_fire && wr_last) begin
            full_next[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    // Register the bank-full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

    // Write pointer and bank: step per accepted sample, swap banks at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read pointer and bank: step per loaded sample, swap banks after the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_last) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Output register: load the next bit-reversed sample or go idle holding data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_last  <= 1'b0;
            bus.out_bank  <= 1'b0;
        end else if (rd_advance) begin
            if (full[rd_bank]) begin
                bus.out_valid <= 1'b1;
                bus.out_re    <= rd_data[2*DATA_W-1:DATA_W];
                bus.out_im    <= rd_data[DATA_W-1:0];
                bus.out_last  <= rd_last;
                bus.out_bank  <= rd_bank;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
